// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Oversamples RxD with the system clock,
//               centres sampling on each bit and hands every correctly framed
//               byte to the consumer on a level valid / ack handshake, with
//               1-cycle framing-error and overrun pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active low
    input  logic       RxD,
    input  logic       data_ack,
    output logic [7:0] dataOut,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] state_debug
);

    // Counter only ever has to reach CLKS_PER_BIT-1
    localparam int                  c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(HALF_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    logic               r_sync1;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_data_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_stop_sample;
    logic               w_good_stop;
    logic               w_bad_stop;

    // Stop bit is judged at its centre; good/bad decides the output update
    assign w_stop_sample = (r_state == c_STOP) && (r_cnt == c_BIT_LAST);
    assign w_good_stop   = w_stop_sample &&  r_rx_s;
    assign w_bad_stop    = w_stop_sample && !r_rx_s;

    assign dataOut     = r_data;
    assign data_valid  = r_data_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign busy        = (r_state != c_IDLE);
    assign state_debug = r_state;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_rx_s  <= r_sync1;
        end
    end

    // Frame FSM: start detect, mid-bit sampling of 8 data bits, stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= c_START;
                        r_cnt   <= '0;
                    end
                end
                c_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        // A start bit that has gone high again was a glitch
                        if (!r_rx_s) begin
                            r_state   <= c_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};   // LSB arrives first
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        // Leave at mid-stop so a directly following start is seen
                        r_state <= r_rx_s ? c_IDLE : c_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_WAIT_IDLE: begin
                    // Line held low (break / stuck): wait for idle before rearming
                    if (r_rx_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output register and valid/ack handshake with error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data       <= 8'd0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            // An ack on the completion edge consumes the old byte: no overrun
            r_overrun   <= w_good_stop && r_data_valid && !data_ack;
            if (w_good_stop) begin
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
            end else if (data_ack) begin
                r_data_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receiving end of the serial link that the analyzer's TxD path drives.
- Used on the analyzer side to accept host commands (trigger config, arm, channel select).
- Also used in loopback benches to check TxD output byte-for-byte.
- Oversamples RxD with the system clock and presents each byte on a valid/ack handshake, with framing and overrun flags.

Parameters:
- CLKS_PER_BIT, 87, system clocks per bit period (10 MHz / 115200 ≈ 87). Must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2, sample offset from the bit start, in clocks (integer division).

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous active-low reset; asserting (low) clears all state immediately
- RxD  in  1  serial line, idle high, asynchronous to clk
- data_ack  in  1  consumer has taken dataOut; sampled on the rising edge
- dataOut  out  8  last correctly framed byte
- data_valid  out  1  level; dataOut holds an unconsumed byte
- frame_err  out  1  1-cycle pulse; stop bit sampled low
- overrun  out  1  1-cycle pulse; a new byte overwrote an unacknowledged byte
- busy  out  1  high in any state except IDLE
- state_debug  out  3  current FSM state encoding

Behaviour:
- Reset values: dataOut=0, data_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, bit counter=0, clock counter=0. The synchronizer flops reset to 1.
- RxD passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- State encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
- IDLE:
  - rx_s==0 → START; clock counter cleared.
- START:
  - Count to HALF_BIT-1, then sample rx_s.
  - 0 → DATA, counter cleared, bit index=0.
  - 1 → glitch: IDLE, no flags.
- DATA:
  - Count to CLKS_PER_BIT-1 (mid-bit), sample rx_s into shift register, LSB first.
  - After bit index 7 is sampled → STOP; otherwise index+1.
- STOP:
  - Count to CLKS_PER_BIT-1, sample rx_s.
  - 1 (good stop):
    - dataOut ← shift register, data_valid←1 on the next edge.
    - If data_valid was already 1 and data_ack is not asserted on that same edge, overrun pulses for 1 cycle. The new byte still overwrites dataOut.
    - Next state IDLE.
  - 0: frame_err pulses for 1 cycle; dataOut and data_valid are unchanged → WAIT_IDLE.
- WAIT_IDLE: stays here until rx_s==1 (break or line-stuck-low), then → IDLE. No new start is detected while in this state.
- Handshake:
  - data_ack with data_valid=1 clears data_valid on that edge.
  - data_ack with data_valid=0 is ignored.
  - If a byte completes on the same edge as data_ack, the ack consumes the old byte: data_valid stays 1, no overrun.
- Latency:
  - data_valid rises 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 clocks after the first clk edge that registers RxD low.
  - With CLKS_PER_BIT=8, HALF_BIT=4: 79 clocks. Tolerance ±1 clock for synchronizer phase.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- busy=0 only in IDLE.
- state_debug mirrors the state register combinationally.
- Mid-frame reset: all outputs return to reset values immediately. After release, the remainder of the interrupted frame is treated as line activity:
  - any low level starts a new frame search;
  - a partial frame may produce a frame_err, which is acceptable;
  - no byte is delivered unless a full valid frame is seen.

Test Plan (CLKS_PER_BIT=8, bit = 800 ns at 10 MHz):
- Reset held 200 ns, RxD=1 → all outputs 0, state_debug=0, busy=0. Send frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → dataOut=0xA5, data_valid=1 at 79±1 clocks after start edge, frame_err=0. Pulse data_ack → data_valid=0 next edge.
- Two back-to-back frames 0x3C, 0xC3 without ack → first: dataOut=0x3C, data_valid=1. Second: dataOut=0xC3, overrun pulses exactly 1 cycle, data_valid stays 1.
- Frame 0x55 with stop bit driven 0 for 3 bit times → frame_err 1-cycle pulse, data_valid stays 0, state_debug=4 until RxD returns high, then 0. Follow with 0x81 → dataOut=0x81 received correctly.
- RxD low glitch of 2 clocks (shorter than HALF_BIT) in IDLE → returns to IDLE, no data_valid, no frame_err, dataOut unchanged.
- data_ack asserted on the exact edge a second byte 0x7E completes → data_valid stays 1, dataOut=0x7E, overrun stays 0.
- rst pulsed low mid-DATA of frame 0xF0 → outputs immediately reset. Next full frame 0x0F → dataOut=0x0F, data_valid=1.
